tune_sequencer: RTL and testbench

//  Parametrised melody player: a writable note RAM replaces a fixed tune table, and a

---
 rtl/tune_pkg.sv | 42 ++++
 rtl/tone_gen.sv | 34 +++
 rtl/tune_sequencer.sv | 166 ++++++++++++++++
 tb/tb_tune_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tune_pkg.sv
// Shared types and lookup helpers for the tune sequencer.
package tune_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_GAP
    } state_t;

    // Tone half-period in prescaler ticks for each pitch index.
    // Index 0 is a rest; index 1 is a very short test tone; 2..15 run D4..C6
    // assuming a ~537.6 kHz tick (50 MHz / 93).
    function automatic int unsigned half_period(input int unsigned idx);
        case (idx)
            0:       return 0;
            1:       return 2;
            2:       return 914;
            3:       return 815;
            4:       return 770;
            5:       return 686;
            6:       return 611;
            7:       return 544;
            8:       return 514;
            9:       return 458;
            10:      return 408;
            11:      return 385;
            12:      return 343;
            13:      return 305;
            14:      return 272;
            15:      return 257;
            default: return 0;
        endcase
    endfunction

    // Duration code 0..3 maps to 1..4 beats.
    function automatic int unsigned dur_beats(input logic [1:0] dur);
        return 32'(dur) + 1;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Prescaled square-wave divider: toggles the output every half_i ticks while enabled.
module tone_gen #(
    parameter int DIV_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic [DIV_W-1:0] half_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic             tone_o
);

    logic [DIV_W-1:0] cnt;

    // Half-period counter and output toggle; silent when disabled, cleared or rest.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            tone_o <= 1'b0;
        end else if (clr_i || !en_i || half_i == '0) begin
            cnt    <= '0;
            tone_o <= 1'b0;
        end else if (tick_i) begin
            if (cnt == half_i - DIV_W'(1)) begin
                cnt    <= '0;
                tone_o <= ~tone_o;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/tune_sequencer.sv
// Melody player: note RAM, sequencing FSM with play/gap timing, tone output and heartbeat.
module tune_sequencer
    import tune_pkg::*;
#(
    parameter int CLK_DIV      = 93,
    parameter int DEPTH_LOG2   = 6,
    parameter int PITCH_W      = 4,
    parameter int DIV_W        = 10,
    parameter int BEAT_TICKS   = 256,
    parameter int GAP_TICKS    = 32,
    parameter int BLINK_PERIOD = 5000000
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [PITCH_W+1:0]    wr_data_i,
    input  logic [DEPTH_LOG2-1:0] last_i,
    input  logic                  loop_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DEPTH_LOG2-1:0] pc_o,
    output logic                  tone_o,
    output logic                  blink_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam int LEN_W = $clog2(4 * BEAT_TICKS + 1);
    localparam int BLK_W = $clog2(BLINK_PERIOD);

    logic [PITCH_W+1:0] ram [DEPTH];
    logic [PITCH_W+1:0] rd_data;

    state_t             state;
    logic [PRE_W-1:0]   presc;
    logic [PITCH_W-1:0] pitch;
    logic [LEN_W-1:0]   play_len;
    logic [LEN_W-1:0]   dur_cnt;
    logic [DIV_W-1:0]   half;
    logic [BLK_W-1:0]   blink_cnt;

    logic tick, play_end, gap_end, last_hit, enter_fetch, tone_en;

    assign tick        = (presc == PRE_W'(CLK_DIV - 1));
    assign play_end    = (state == ST_PLAY) && tick && (dur_cnt == play_len - LEN_W'(1));
    assign gap_end     = (state == ST_GAP) && tick && (dur_cnt == LEN_W'(GAP_TICKS - 1));
    // >= rather than == so a last_i lowered mid-play still ends the tune.
    assign last_hit    = (pc_o >= last_i);
    assign enter_fetch = !stop_i && (((state == ST_IDLE) && start_i) ||
                                     (gap_end && (!last_hit || loop_i)));
    // Drop enable on the final PLAY tick so tone_o is already low on the first GAP cycle.
    assign tone_en     = (state == ST_PLAY) && !play_end && !stop_i;
    assign half        = DIV_W'(half_period(32'(pitch)));

    // Note RAM: synchronous write, registered read issued in FETCH (old data on collision).
    always_ff @(posedge clk_i) begin
        if (wr_en_i)
            ram[wr_addr_i] <= wr_data_i;
        if (state == ST_FETCH)
            rd_data <= ram[pc_o];
    end

    // Tick prescaler, realigned at every note fetch so note timing is start-relative.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (enter_fetch || tick)
            presc <= '0;
        else
            presc <= presc + PRE_W'(1);
    end

    // Sequencer FSM: fetch, load, play, gap, then advance / loop / finish.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc_o     <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            pitch    <= '0;
            play_len <= '0;
            dur_cnt  <= '0;
        end else begin
            done_o <= 1'b0;
            if (stop_i) begin
                state  <= ST_IDLE;
                pc_o   <= '0;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            state  <= ST_FETCH;
                            busy_o <= 1'b1;
                        end
                    end
                    ST_FETCH: state <= ST_LOAD;
                    ST_LOAD: begin
                        pitch    <= rd_data[PITCH_W+1:2];
                        play_len <= LEN_W'(dur_beats(rd_data[1:0]) * 32'(BEAT_TICKS)
                                           - 32'(GAP_TICKS));
                        dur_cnt  <= '0;
                        state    <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (play_end) begin
                            dur_cnt <= '0;
                            state   <= ST_GAP;
                        end else if (tick) begin
                            dur_cnt <= dur_cnt + LEN_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (gap_end) begin
                            dur_cnt <= '0;
                            if (!last_hit) begin
                                pc_o  <= pc_o + DEPTH_LOG2'(1);
                                state <= ST_FETCH;
                            end else if (loop_i) begin
                                pc_o  <= '0;
                                state <= ST_FETCH;
                            end else begin
                                pc_o   <= '0;
                                state  <= ST_IDLE;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                            end
                        end else if (tick) begin
                            dur_cnt <= dur_cnt + LEN_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    tone_gen #(
        .DIV_W (DIV_W)
    ) u_tone (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .tick_i (tick),
        .half_i (half),
        .en_i   (tone_en),
        .clr_i  (state == ST_LOAD),
        .tone_o (tone_o)
    );

    // Free-running heartbeat, independent of the sequencer.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_o   <= 1'b0;
        end else if (blink_cnt == BLK_W'(BLINK_PERIOD - 1)) begin
            blink_cnt <= '0;
            blink_o   <= ~blink_o;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed bench for tune_sequencer with a per-cycle expected-output scoreboard.
module tb_tune_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [5:0] wr_data = '0;
    logic [2:0] last = '0;
    logic       loop_en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy, done, tone, blink;
    logic [2:0] pc;

    typedef struct {
        logic       tone;
        logic       busy;
        logic       done;
        logic [2:0] pc;
    } exp_t;

    exp_t sbq[$];
    int   pcq[$];
    int   checks = 0;
    int   errors = 0;

    tune_sequencer #(
        .CLK_DIV      (4),
        .DEPTH_LOG2   (3),
        .PITCH_W      (4),
        .DIV_W        (10),
        .BEAT_TICKS   (8),
        .GAP_TICKS    (2),
        .BLINK_PERIOD (10)
    ) dut (
        .clk_i     (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .last_i    (last),
        .loop_i    (loop_en),
        .start_i   (start),
        .stop_i    (stop),
        .busy_o    (busy),
        .done_o    (done),
        .pc_o      (pc),
        .tone_o    (tone),
        .blink_o   (blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [2:0] a, input logic [3:0] p, input logic [1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = {p, d};
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns at the falling edge after the start edge (k = 1).
    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Expected outputs for consecutive 1-beat notes: each note is 32 clk
    // (FETCH, LOAD, 22 PLAY, 8 GAP); pitch-1 tone is high for k = 9..16 of each note.
    task automatic push_exp(input int kmax, input logic [3:0] pitched, input int nn);
        exp_t e;
        for (int k = 1; k <= kmax; k++) begin
            int j, r;
            j = (k - 1) / 32;
            r = k - 32 * j;
            e.tone = (j < nn) ? (pitched[j] && r >= 9 && r <= 16) : 1'b0;
            e.busy = (k <= 32 * nn);
            e.done = (k == 32 * nn + 1);
            e.pc   = (j < nn) ? 3'(j) : 3'd0;
            sbq.push_back(e);
        end
    endtask

    // Pop and compare one scoreboard entry per cycle; optional RAM write at cycle wk.
    task automatic run_check(input string tag, input int kmax, input int wk,
                             input logic [2:0] wa, input logic [5:0] wd);
        exp_t e;
        for (int k = 1; k <= kmax; k++) begin
            if (sbq.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'(sbq.size()), 32'(1));
                break;
            end
            e = sbq.pop_front();
            chk($sformatf("%s.k%0d.tone", tag, k), 32'(tone), 32'(e.tone));
            chk($sformatf("%s.k%0d.busy", tag, k), 32'(busy), 32'(e.busy));
            chk($sformatf("%s.k%0d.done", tag, k), 32'(done), 32'(e.done));
            chk($sformatf("%s.k%0d.pc",   tag, k), 32'(pc),   32'(e.pc));
            wr_en = (k == wk); wr_addr = wa; wr_data = wd;
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        int   n, prev_pc, cnt, ntog;
        logic saw_tone, saw_done, prevb;

        // Reset state
        #1;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.pc", 32'(pc), 0);
        chk("rst.tone", 32'(tone), 0);
        chk("rst.blink", 32'(blink), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pitch-1 note, no loop
        wr(3'd0, 4'd1, 2'd0);
        last = 3'd0; loop_en = 1'b0;
        push_exp(40, 4'b0001, 1);
        start_pulse();
        run_check("single", 40, 0, 3'd0, 6'd0);

        // Three rests, looping: pc advances every 32 clk, no tone, no done
        wr(3'd0, 4'd0, 2'd0);
        wr(3'd1, 4'd0, 2'd0);
        wr(3'd2, 4'd0, 2'd0);
        last = 3'd2; loop_en = 1'b1;
        pcq = '{1, 2, 0, 1, 2};
        start_pulse();
        prev_pc = 0; saw_tone = 1'b0; saw_done = 1'b0;
        while (pcq.size() > 0) begin
            int want;
            want = pcq.pop_front();
            n = 0;
            while (pc === 3'(prev_pc) && n < 40) begin
                saw_tone |= tone; saw_done |= done;
                @(negedge clk);
                n++;
            end
            chk("loop.interval", n, 32);
            chk("loop.pc", 32'(pc), want);
            prev_pc = int'(pc);
        end
        chk("loop.no_tone", 32'(saw_tone), 0);
        chk("loop.no_done", 32'(saw_done), 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("loop.stop_busy", 32'(busy), 0);
        chk("loop.stop_pc", 32'(pc), 0);
        loop_en = 1'b0;

        // stop with start in the same cycle: stop wins
        wr(3'd0, 4'd1, 2'd0);
        wr(3'd1, 4'd1, 2'd0);
        last = 3'd0;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("ss.busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        chk("ss.busy_later", 32'(busy), 0);

        // stop mid-PLAY of the second note
        last = 3'd1;
        start_pulse();
        repeat (44) @(negedge clk);
        chk("mid.tone_before", 32'(tone), 1);
        chk("mid.pc_before", 32'(pc), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("mid.busy", 32'(busy), 0);
        chk("mid.tone", 32'(tone), 0);
        chk("mid.pc", 32'(pc), 0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            saw_done |= done;
            @(negedge clk);
        end
        chk("mid.no_done", 32'(saw_done), 0);

        // Rewrite RAM[1] (rest -> pitch 1) while pc=0 is playing
        wr(3'd0, 4'd1, 2'd0);
        wr(3'd1, 4'd0, 2'd0);
        last = 3'd1;
        push_exp(72, 4'b0011, 2);
        start_pulse();
        run_check("wrbusy", 72, 5, 3'd1, {4'd1, 2'd0});

        // Write RAM[0] in its FETCH cycle: old (pitch 1) is played, new (rest) next time
        wr(3'd0, 4'd1, 2'd0);
        last = 3'd0;
        push_exp(40, 4'b0001, 1);
        start_pulse();
        run_check("rdold", 40, 1, 3'd0, {4'd0, 2'd0});
        push_exp(40, 4'b0000, 1);
        start_pulse();
        run_check("rdnew", 40, 0, 3'd0, 6'd0);

        // Reset mid-PLAY: outputs drop immediately
        wr(3'd0, 4'd1, 2'd0);
        start_pulse();
        repeat (11) @(negedge clk);
        chk("rstmid.tone_before", 32'(tone), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid.tone", 32'(tone), 0);
        chk("rstmid.busy", 32'(busy), 0);
        chk("rstmid.done", 32'(done), 0);
        chk("rstmid.pc", 32'(pc), 0);
        chk("rstmid.blink", 32'(blink), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Heartbeat toggles every 10 clk regardless of start/stop activity
        prevb = blink; cnt = 0; ntog = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            cnt++;
            if (i == 1) chk("rstmid.idle", 32'(busy), 0);
            if (blink !== prevb) begin
                chk("blink.interval", cnt, 10);
                cnt = 0;
                ntog++;
            end
            prevb = blink;
            start = (i == 3 || i == 30);
            stop  = (i == 17);
        end
        start = 1'b0; stop = 1'b0;
        chk("blink.toggles", ntog, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
